// File: rtl/psum_drain_if.sv
// Handshake and data bundle between the psum drain controller, the PE column and the output consumer.
// master = drain controller side, slave = column/consumer side.
interface psum_drain_if #(
    parameter int unsigned ROWS   = 8,
    parameter int unsigned PSU_DW = 32
);
    localparam int unsigned RW = $clog2(ROWS);

    logic              start;
    logic              start_ready;
    logic              psum_sel;
    logic [PSU_DW-1:0] col_in;
    logic [PSU_DW-1:0] out_data;
    logic [RW-1:0]     out_row;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, col_in, out_ready,
        output start_ready, psum_sel, out_data, out_row, out_last, out_valid, busy, done
    );

    modport slave (
        output start, col_in, out_ready,
        input  start_ready, psum_sel, out_data, out_row, out_last, out_valid, busy, done
    );
endinterface

// File: rtl/psum_drain.sv
// Drains one PE column's partial sums (bottom row first) into a show-ahead FIFO
// and presents them on a valid/ready stream tagged with their source row.
module psum_drain #(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned PSU_DW     = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    psum_drain_if.master   bus
);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [PSU_DW-1:0] data;
        logic [RW-1:0]     row;
        logic              last;
    } entry_t;

    typedef enum logic [1:0] {IDLE, SEL, CAP} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] k_q, k_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        wr_entry;
    logic          push;
    logic          pop;
    logic          room;
    logic          last_row;

    // A drain is only admitted when the whole column is guaranteed to fit.
    assign room     = (CW'(FIFO_DEPTH) - count_q) >= CW'(ROWS);
    assign last_row = (k_q == RW'(ROWS - 1));

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        push     = 1'b0;
        pop      = (count_q != '0) && bus.out_ready;
        wr_entry = '{data: bus.col_in, row: RW'(ROWS - 1) - k_q, last: last_row};

        case (state_q)
            IDLE: if (bus.start && room) state_d = SEL;
            SEL: begin
                state_d = CAP;
                k_d     = '0;
            end
            CAP: begin
                push = 1'b1;
                k_d  = k_q + RW'(1);
                if (last_row) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        wr_d = push ? wr_q + AW'(1) : wr_q;
        rd_d = pop  ? rd_q + AW'(1) : rd_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage is left unreset; entries are only observable while count is nonzero.
    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_q] <= wr_entry;
    end

    assign bus.start_ready = (state_q == IDLE) && room;
    assign bus.psum_sel    = (state_q == SEL);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == CAP) && last_row;
    assign bus.out_valid   = (count_q != '0);
    assign bus.out_data    = mem_q[rd_q].data;
    assign bus.out_row     = mem_q[rd_q].row;
    assign bus.out_last    = mem_q[rd_q].last;
endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain with ROWS=4, PSU_DW=32, FIFO_DEPTH=8.
module tb_psum_drain;
    localparam int unsigned ROWS   = 4;
    localparam int unsigned PSU_DW = 32;
    localparam int unsigned DEPTH  = 8;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t obs [$];
    ent_t exp_q [$];

    psum_drain_if #(.ROWS(ROWS), .PSU_DW(PSU_DW)) bus ();

    psum_drain #(.ROWS(ROWS), .PSU_DW(PSU_DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    // Advance one cycle; a pop happening at this edge is logged first.
    task automatic tick();
        if (bus.out_valid && bus.out_ready)
            obs.push_back({bus.out_data, bus.out_row, bus.out_last});
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && bus.out_valid; i++) tick();
    endtask

    // Runs one drain from the current cycle T; returns in T+6 with per-cycle masks.
    task automatic drain(input logic [31:0] d3, input logic [31:0] d2,
                         input logic [31:0] d1, input logic [31:0] d0,
                         output int sel_m, output int done_m, output int busy_m);
        logic [31:0] dv [4];
        dv[0] = d3; dv[1] = d2; dv[2] = d1; dv[3] = d0;
        sel_m = 0; done_m = 0; busy_m = 0;
        bus.start = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c >= 2 && c <= 5) bus.col_in = dv[c-2];
            sel_m  |= int'(bus.psum_sel) << c;
            done_m |= int'(bus.done) << c;
            busy_m |= int'(bus.busy) << c;
            if (c < 6) tick();
            bus.start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready: got %b want 1", bus.start_ready); end
        n_tests++; if ({bus.busy, bus.psum_sel, bus.done} !== 3'b000) begin n_fail++; $display("FAIL reset_busy_sel_done: got %b want 000", {bus.busy, bus.psum_sel, bus.done}); end
    endtask

    task automatic test_basic();
        int s, d, b;
        obs.delete();
        bus.out_ready = 1'b1;
        drain(32'h40, 32'h30, 32'h20, 32'h10, s, d, b);
        n_tests++; if (s !== 32'h2) begin n_fail++; $display("FAIL basic_psum_sel: got mask %h want 2", s); end
        n_tests++; if (d !== 32'h20) begin n_fail++; $display("FAIL basic_done: got mask %h want 20", d); end
        n_tests++; if (b !== 32'h3e) begin n_fail++; $display("FAIL basic_busy: got mask %h want 3e", b); end
        flush();
        exp_q = '{{32'h40, 2'd3, 1'b0}, {32'h30, 2'd2, 1'b0}, {32'h20, 2'd1, 1'b0}, {32'h10, 2'd0, 1'b1}};
        n_tests++; if (obs.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d entries want 4", obs.size()); end
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            n_tests++; if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_entry%0d: got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        int s, d, b;
        obs.delete();
        bus.out_ready = 1'b0;
        drain(32'hA3, 32'hA2, 32'hA1, 32'hA0, s, d, b);
        n_tests++; if (bus.start_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_first: got %b want 1", bus.start_ready); end
        drain(32'hB3, 32'hB2, 32'hB1, 32'hB0, s, d, b);
        n_tests++; if (dut.count_q !== 4'd8) begin n_fail++; $display("FAIL bp_count8: got %0d want 8", dut.count_q); end
        n_tests++; if (bus.start_ready !== 1'b0) begin n_fail++; $display("FAIL bp_third_ready: got %b want 0", bus.start_ready); end
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if ({bus.busy, bus.psum_sel} !== 2'b00) begin n_fail++; $display("FAIL bp_third_ignored: got %b want 00", {bus.busy, bus.psum_sel}); end
            n_tests++; if ({bus.out_data, bus.out_row, bus.out_last} !== {32'hA3, 2'd3, 1'b0}) begin n_fail++; $display("FAIL bp_stall_stable: got %h/%0d/%b want a3/3/0", bus.out_data, bus.out_row, bus.out_last); end
        end
        bus.start = 1'b0;
        flush();
        exp_q = '{{32'hA3, 2'd3, 1'b0}, {32'hA2, 2'd2, 1'b0}, {32'hA1, 2'd1, 1'b0}, {32'hA0, 2'd0, 1'b1},
                  {32'hB3, 2'd3, 1'b0}, {32'hB2, 2'd2, 1'b0}, {32'hB1, 2'd1, 1'b0}, {32'hB0, 2'd0, 1'b1}};
        n_tests++; if (obs.size() != 8) begin n_fail++; $display("FAIL bp_pop_count: got %0d want 8", obs.size()); end
        for (int i = 0; i < 8 && i < obs.size(); i++) begin
            n_tests++; if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_entry%0d: got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_threshold();
        int s, d, b;
        bus.out_ready = 1'b0;
        drain(32'h13, 32'h12, 32'h11, 32'h10, s, d, b);
        drain(32'h23, 32'h22, 32'h21, 32'h20, s, d, b);
        bus.out_ready = 1'b1;
        tick(); tick(); tick();
        bus.out_ready = 1'b0;
        n_tests++; if (dut.count_q !== 4'd5) begin n_fail++; $display("FAIL thr_count5: got %0d want 5", dut.count_q); end
        n_tests++; if (bus.start_ready !== 1'b0) begin n_fail++; $display("FAIL thr_ready_at5: got %b want 0", bus.start_ready); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_tests++; if (bus.start_ready !== 1'b1) begin n_fail++; $display("FAIL thr_ready_at4: got %b want 1", bus.start_ready); end
        flush();
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL thr_flushed: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_simul();
        int s, d, b;
        logic [31:0] dv [4];
        dv[0] = 32'hD3; dv[1] = 32'hD2; dv[2] = 32'hD1; dv[3] = 32'hD0;
        bus.out_ready = 1'b0;
        drain(32'hC3, 32'hC2, 32'hC1, 32'hC0, s, d, b);
        bus.out_ready = 1'b1;
        tick(); tick(); tick();
        bus.out_ready = 1'b0;
        obs.delete();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.col_in = dv[i];
            n_tests++; if (dut.count_q !== 4'd1) begin n_fail++; $display("FAIL simul_count_cap%0d: got %0d want 1", i, dut.count_q); end
            tick();
        end
        n_tests++; if (dut.count_q !== 4'd1) begin n_fail++; $display("FAIL simul_count_end: got %0d want 1", dut.count_q); end
        flush();
        exp_q = '{{32'hC0, 2'd0, 1'b1}, {32'hD3, 2'd3, 1'b0}, {32'hD2, 2'd2, 1'b0}, {32'hD1, 2'd1, 1'b0}, {32'hD0, 2'd0, 1'b1}};
        n_tests++; if (obs.size() != 5) begin n_fail++; $display("FAIL simul_pop_count: got %0d want 5", obs.size()); end
        for (int i = 0; i < 5 && i < obs.size(); i++) begin
            n_tests++; if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL simul_entry%0d: got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_start_busy();
        obs.delete();
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        for (int c = 1; c <= 5; c++) begin
            if (c >= 2) bus.col_in = 32'h50 + 32'(c);
            n_tests++; if (bus.psum_sel !== (c == 1)) begin n_fail++; $display("FAIL busy_sel_c%0d: got %b want %b", c, bus.psum_sel, c == 1); end
            n_tests++; if (bus.done !== (c == 5)) begin n_fail++; $display("FAIL busy_done_c%0d: got %b want %b", c, bus.done, c == 5); end
            tick();
        end
        n_tests++; if ({bus.busy, bus.start_ready} !== 2'b01) begin n_fail++; $display("FAIL busy_idle_gap: got %b want 01", {bus.busy, bus.start_ready}); end
        tick();
        bus.start = 1'b0;
        n_tests++; if (bus.psum_sel !== 1'b1) begin n_fail++; $display("FAIL busy_next_drain: got %b want 1", bus.psum_sel); end
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.col_in = 32'h60 + 32'(i);
            tick();
        end
        flush();
        n_tests++; if (obs.size() != 8) begin n_fail++; $display("FAIL busy_total_entries: got %0d want 8", obs.size()); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.col_in = 32'h77;
        tick(); tick();
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rmid_done_k2: got %b want 0", bus.done); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if ({bus.busy, bus.out_valid, bus.done, bus.psum_sel} !== 4'b0000) begin n_fail++; $display("FAIL rmid_after: busy/valid/done/sel got %b want 0000", {bus.busy, bus.out_valid, bus.done, bus.psum_sel}); end
        n_tests++; if (bus.start_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", bus.start_ready); end
        tick();
        n_tests++; if ({bus.out_valid, bus.done} !== 2'b00) begin n_fail++; $display("FAIL rmid_settled: got %b want 00", {bus.out_valid, bus.done}); end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.col_in    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_threshold();
        test_simul();
        test_start_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
